tl_get_arbiter: RTL

- Shares one downstream TileLink-UL read port (GET only, 64-bit D data) between two requesters.
- Port m0 is the high-priority video scanout fetcher (text and graphic line loads). Port m1 is a low-priority secondary reader such as a blitter or audio DMA.
- Remaps source IDs so D responses route back to the correct requester, and tracks outstanding requests per port.
- Sits between the video/DMA masters and the cache/memory bus.

---
 rtl/tl_get_if.sv | 30 +++
 rtl/tl_get_arbiter.sv | 75 +++++++
 2 files changed

// File: rtl/tl_get_if.sv
// tl_get_if: TileLink-UL GET-only A/D channel pair with 64-bit D data.
interface tl_get_if #(
  parameter int AW = 32,
  parameter int SW = 2
);
  logic          a_valid;
  logic          a_ready;
  logic [2:0]    a_opcode;
  logic [2:0]    a_param;
  logic [2:0]    a_size;
  logic [SW-1:0] a_source;
  logic [AW-1:0] a_address;
  logic          d_valid;
  logic          d_ready;
  logic [2:0]    d_opcode;
  logic [2:0]    d_param;
  logic [2:0]    d_size;
  logic [SW-1:0] d_source;
  logic          d_denied;
  logic          d_corrupt;
  logic [63:0]   d_data;
  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data
  );
  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data
  );
endinterface

// File: rtl/tl_get_arbiter.sv
// tl_get_arbiter: shares one TileLink-UL GET port between a priority port m0 and a starvation-guarded port m1.
module tl_get_arbiter #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 64
) (
  input logic     clk,
  input logic     reset_n,
  tl_get_if.slave  m0,
  tl_get_if.slave  m1,
  tl_get_if.master s,
  output logic    idle
);
  logic       grant, hold, g, e0, e1, sav, sdr, fire0, fire1, p, d_fire, last, dec0, dec1;
  logic [2:0] out0, out1, beat, last_beat;
  logic [7:0] starve;
  always_comb begin
    e0 = m0.a_valid & (out0 < 3'(MAX_OUTSTANDING));
    e1 = m1.a_valid & (out1 < 3'(MAX_OUTSTANDING));
    g = hold ? grant : (e1 & (~e0 | (starve >= 8'(STARVE_LIMIT)))) ? 1'b1 : e0 ? 1'b0 : grant;
    sav = reset_n & (g ? e1 : e0);
    fire0 = sav & s.a_ready & ~g;
    fire1 = sav & s.a_ready & g;
    s.a_valid = sav;
    s.a_opcode = g ? m1.a_opcode : m0.a_opcode;
    s.a_param = g ? m1.a_param : m0.a_param;
    s.a_size = g ? m1.a_size : m0.a_size;
    s.a_source = {g, g ? m1.a_source : m0.a_source};
    s.a_address = ADDRESS_WIDTH'(g ? m1.a_address : m0.a_address);
    m0.a_ready = fire0;
    m1.a_ready = fire1;
    p = s.d_source[2];
    sdr = reset_n & (p ? m1.d_ready : m0.d_ready);
    s.d_ready = sdr;
    m0.d_valid = reset_n & s.d_valid & ~p;
    m1.d_valid = reset_n & s.d_valid & p;
    m0.d_opcode = s.d_opcode;
    m1.d_opcode = s.d_opcode;
    m0.d_param = s.d_param;
    m1.d_param = s.d_param;
    m0.d_size = s.d_size;
    m1.d_size = s.d_size;
    m0.d_source = s.d_source[1:0];
    m1.d_source = s.d_source[1:0];
    m0.d_denied = s.d_denied;
    m1.d_denied = s.d_denied;
    m0.d_corrupt = s.d_corrupt;
    m1.d_corrupt = s.d_corrupt;
    m0.d_data = s.d_data;
    m1.d_data = s.d_data;
    // bursts of 2^(size-3) beats for sizes above one 64-bit beat
    last_beat = (s.d_size <= 3'd3) ? 3'd0 : 3'((4'd1 << (s.d_size - 3'd3)) - 4'd1);
    d_fire = s.d_valid & sdr;
    last = beat == last_beat;
    dec0 = d_fire & last & ~p & (out0 != 3'd0);
    dec1 = d_fire & last & p & (out1 != 3'd0);
    idle = (out0 == 3'd0) & (out1 == 3'd0) & (beat == 3'd0);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      grant <= 1'b0;
      hold <= 1'b0;
      out0 <= 3'd0;
      out1 <= 3'd0;
      starve <= 8'd0;
      beat <= 3'd0;
    end else begin
      grant <= g;
      hold <= sav & ~s.a_ready;
      out0 <= out0 + 3'(fire0) - 3'(dec0);
      out1 <= out1 + 3'(fire1) - 3'(dec1);
      starve <= (fire1 | ~m1.a_valid) ? 8'd0 : (e1 & ~&starve) ? starve + 8'd1 : starve;
      if (d_fire) beat <= last ? 3'd0 : beat + 3'd1;
    end
endmodule
